// File: rtl/inst_feeder.sv
// inst_feeder: FIFO-buffered, bit-reversing instruction feeder for the minimips core (define INST_FEED_CNT_EN for issue/starve counters)
module inst_feeder #(
   parameter int DEPTH = 8
) (
   input  logic                     cpu_clk_50M,
   input  logic                     cpu_rst_n,
   input  logic                     wr_valid,
   input  logic [31:0]              wr_inst,
   output logic                     wr_ready,
   input  logic                     start_i,
   input  logic                     stop_i,
   input  logic                     flush_i,
   input  logic                     hold_i,
   output logic [31:0]              outer_inst,
   output logic                     en,
   output logic [$clog2(DEPTH):0]   level_o,
   output logic                     empty_o,
   output logic                     full_o,
   output logic                     busy_o
`ifdef INST_FEED_CNT_EN
   ,
   output logic [31:0]              issue_cnt_o,
   output logic [15:0]              starve_cnt_o
`endif
);
   localparam int AW = $clog2(DEPTH);
   typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;
   state_t state, state_nx;
   logic [AW:0] wp, rp;
   logic [31:0] mem [DEPTH];
   logic [31:0] head;
   logic push, issue, drained;
   assign empty_o  = wp == rp;
   assign full_o   = (wp[AW] != rp[AW]) && (wp[AW-1:0] == rp[AW-1:0]);
   assign level_o  = wp - rp;
   assign busy_o   = state != IDLE;
   assign wr_ready = !full_o && state != DRAIN;
   assign push     = wr_valid && wr_ready && !flush_i;
   assign issue    = state != IDLE && !hold_i && !empty_o && !flush_i;
   assign head     = mem[rp[AW-1:0]];
   // FIFO is empty after this edge: nothing arriving and nothing (or only the last word) left
   assign drained  = !push && (empty_o || (issue && level_o == (AW+1)'(1)));
   // next state ignoring flush, which the sequential block overrides
   always_comb
      state_nx = state == IDLE ? (start_i ? RUN : IDLE) :
                 state == RUN  ? (stop_i ? (drained ? IDLE : DRAIN) : RUN) :
                                 (drained ? IDLE : DRAIN);
   // word storage; stale contents are harmless since pointers define validity
   always_ff @(posedge cpu_clk_50M)
      if (push) mem[wp[AW-1:0]] <= wr_inst;
   // state, pointers and registered issue outputs
   always_ff @(posedge cpu_clk_50M)
      if (!cpu_rst_n || flush_i) begin
         state      <= IDLE;
         wp         <= '0;
         rp         <= '0;
         outer_inst <= '0;
         en         <= 1'b0;
      end else begin
         state <= state_nx;
         wp    <= wp + (AW+1)'(push);
         rp    <= rp + (AW+1)'(issue);
         en    <= issue;
         if (issue) outer_inst <= {<<{head}};
      end
`ifdef INST_FEED_CNT_EN
   // issue counter wraps and survives flush; starve counter saturates and is cleared by flush
   always_ff @(posedge cpu_clk_50M)
      if (!cpu_rst_n) begin
         issue_cnt_o  <= '0;
         starve_cnt_o <= '0;
      end else begin
         if (issue) issue_cnt_o <= issue_cnt_o + 32'd1;
         if (flush_i) starve_cnt_o <= '0;
         else if (state == RUN && !hold_i && empty_o && starve_cnt_o != 16'hFFFF)
            starve_cnt_o <= starve_cnt_o + 16'd1;
      end
`endif
endmodule

// File: tb/tb_inst_feeder.sv
// tb_inst_feeder: queue-model and directed checks for inst_feeder (INST_FEED_CNT_EN adds counter checks)
module tb_inst_feeder;
   localparam int DEPTH = 8;
   logic clk = 0, rst_n = 0, wr_valid = 0, start_i = 0, stop_i = 0, flush_i = 0, hold_i = 0;
   logic [31:0] wr_inst = '0;
   logic wr_ready, en, empty_o, full_o, busy_o;
   logic [31:0] outer_inst;
   logic [3:0] level_o;
`ifdef INST_FEED_CNT_EN
   logic [31:0] issue_cnt_o;
   logic [15:0] starve_cnt_o;
`endif
   int total = 0, bad = 0, en_cnt = 0;
   bit chk_on = 0;
   int st = 0;
   logic [31:0] q[$];
   logic m_en = 0;
   logic [31:0] m_out = '0;
   longint m_issue = 0;
   int m_starve = 0;

   inst_feeder #(.DEPTH(DEPTH)) dut (
      .cpu_clk_50M(clk), .cpu_rst_n(rst_n), .wr_valid(wr_valid), .wr_inst(wr_inst),
      .wr_ready(wr_ready), .start_i(start_i), .stop_i(stop_i), .flush_i(flush_i),
      .hold_i(hold_i), .outer_inst(outer_inst), .en(en), .level_o(level_o),
      .empty_o(empty_o), .full_o(full_o), .busy_o(busy_o)
`ifdef INST_FEED_CNT_EN
      , .issue_cnt_o(issue_cnt_o), .starve_cnt_o(starve_cnt_o)
`endif
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] rev(input logic [31:0] w);
      logic [31:0] r;
      for (int i = 0; i < 32; i++) r[i] = w[31-i];
      return r;
   endfunction

   task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
      total++;
      if (a !== e) begin
         bad++;
         $display("FAIL %s got=%h want=%h at %0t", n, a, e, $time);
      end
   endtask

   task automatic clk1();
      @(posedge clk);
      #2;
   endtask

   // reference model: a word queue plus an IDLE/RUN/DRAIN state number
   always @(posedge clk) begin : model
      bit p, s;
      logic [31:0] w;
      if (!rst_n || flush_i) begin
         q.delete();
         st = 0;
         m_en = 0;
         m_out = '0;
         if (!rst_n) m_issue = 0;
         m_starve = 0;
      end else begin
         p = wr_valid && q.size() < DEPTH && st != 2;
         s = st != 0 && !hold_i && q.size() > 0;
         if (st == 1 && !hold_i && q.size() == 0 && m_starve < 16'hFFFF) m_starve++;
         if (s) begin
            w = q.pop_front();
            m_out = rev(w);
            m_issue++;
         end
         m_en = s;
         if (p) q.push_back(wr_inst);
         if (st == 0 && start_i) st = 1;
         else if (st == 1 && stop_i) st = q.size() == 0 ? 0 : 2;
         else if (st == 2 && q.size() == 0) st = 0;
      end
   end

   // every-cycle comparison of the DUT against the model
   always @(negedge clk) if (chk_on) begin
      if (en) en_cnt++;
      chk("en", {31'd0, en}, {31'd0, m_en});
      chk("outer_inst", outer_inst, m_out);
      chk("level", {28'd0, level_o}, q.size());
      chk("empty", {31'd0, empty_o}, {31'd0, q.size() == 0});
      chk("full", {31'd0, full_o}, {31'd0, q.size() == DEPTH});
      chk("busy", {31'd0, busy_o}, {31'd0, st != 0});
      chk("wr_ready", {31'd0, wr_ready}, {31'd0, q.size() < DEPTH && st != 2});
`ifdef INST_FEED_CNT_EN
      chk("issue_cnt", issue_cnt_o, m_issue[31:0]);
      chk("starve_cnt", {16'd0, starve_cnt_o}, m_starve);
`endif
   end

   initial begin
      clk1();
      clk1();
      chk_on = 1;
      chk("rst en", {31'd0, en}, 0);
      chk("rst outer", outer_inst, 0);
      chk("rst level", {28'd0, level_o}, 0);
      chk("rst empty", {31'd0, empty_o}, 1);
      chk("rst busy", {31'd0, busy_o}, 0);
      rst_n = 1;
      // single ADDIU word
      wr_valid = 1; wr_inst = 32'h2509007F; start_i = 1;
      clk1();
      wr_valid = 0; start_i = 0;
      chk("t1 pre en", {31'd0, en}, 0);
      clk1();
      chk("t1 en", {31'd0, en}, 1);
      chk("t1 outer", outer_inst, 32'hFE0090A4);
      clk1();
      chk("t1 en off", {31'd0, en}, 0);
      chk("t1 outer hold", outer_inst, 32'hFE0090A4);
      stop_i = 1;
      clk1();
      stop_i = 0;
      chk("t1 idle", {31'd0, busy_o}, 0);
      // fill to full in IDLE, ninth push dropped
      for (int i = 0; i < 9; i++) begin
         wr_valid = 1; wr_inst = 32'h1000_0000 + i;
         clk1();
      end
      wr_valid = 0;
      chk("t2 full", {31'd0, full_o}, 1);
      chk("t2 level", {28'd0, level_o}, 8);
      chk("t2 ready", {31'd0, wr_ready}, 0);
      en_cnt = 0;
      start_i = 1;
      clk1();
      start_i = 0;
      repeat (10) clk1();
      chk("t2 issues", en_cnt, 8);
      chk("t2 empty", {31'd0, empty_o}, 1);
      chk("t2 last", outer_inst, 32'hE0000008);
      // continuous stream with a 3-cycle hold
      en_cnt = 0;
      for (int i = 0; i < 20; i++) begin
         wr_valid = 1; wr_inst = 32'hA000_0000 | i;
         hold_i = i >= 8 && i < 11;
         clk1();
      end
      wr_valid = 0; hold_i = 0;
      repeat (8) clk1();
      chk("t3 issues", en_cnt, 20);
      chk("t3 last", outer_inst, rev(32'hA000_0013));
      chk("t3 empty", {31'd0, empty_o}, 1);
      stop_i = 1;
      clk1();
      stop_i = 0;
      // drain five buffered words
      for (int i = 0; i < 5; i++) begin
         wr_valid = 1; wr_inst = 32'h5000_0000 + i;
         clk1();
      end
      wr_valid = 0; start_i = 1; hold_i = 1;
      clk1();
      start_i = 0; stop_i = 1;
      clk1();
      stop_i = 0; wr_valid = 1; wr_inst = 32'hDEAD_BEEF;
      chk("t4 level", {28'd0, level_o}, 5);
      chk("t4 ready", {31'd0, wr_ready}, 0);
      hold_i = 0; en_cnt = 0;
      repeat (4) clk1();
      chk("t4 busy", {31'd0, busy_o}, 1);
      clk1();
      wr_valid = 0;
      chk("t4 idle", {31'd0, busy_o}, 0);
      chk("t4 en", {31'd0, en}, 1);
      chk("t4 level0", {28'd0, level_o}, 0);
      clk1();
      chk("t4 issues", en_cnt, 5);
      // flush with a concurrent push
      for (int i = 0; i < 4; i++) begin
         wr_valid = 1; wr_inst = 32'h4000_0000 + i;
         clk1();
      end
      wr_valid = 0; start_i = 1; hold_i = 1;
      clk1();
      start_i = 0; hold_i = 0; flush_i = 1; wr_valid = 1; wr_inst = 32'h1234_5678;
      clk1();
      flush_i = 0; wr_valid = 0;
      chk("t5 level", {28'd0, level_o}, 0);
      chk("t5 en", {31'd0, en}, 0);
      chk("t5 outer", outer_inst, 0);
      chk("t5 busy", {31'd0, busy_o}, 0);
`ifdef INST_FEED_CNT_EN
      rst_n = 0;
      clk1();
      rst_n = 1;
      chk("t6 rst issue", issue_cnt_o, 0);
      for (int i = 0; i < 6; i++) begin
         wr_valid = 1; wr_inst = 32'h6000_0000 + i;
         clk1();
      end
      wr_valid = 0; start_i = 1;
      clk1();
      start_i = 0;
      repeat (16) clk1();
      chk("t6 issue", issue_cnt_o, 6);
      chk("t6 starve", {16'd0, starve_cnt_o}, 10);
      flush_i = 1;
      clk1();
      flush_i = 0;
      chk("t6 starve clr", {16'd0, starve_cnt_o}, 0);
      chk("t6 issue kept", issue_cnt_o, 6);
`endif
      clk1();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
